fetch_request_tracker: RTL and testbench
========================================

# fetch_request_tracker

Parametrised in-order tracker for outstanding instruction-fetch requests in the CVA5 fetch stage. It records per-request attributes at issue, matches sub-unit responses to the oldest request, and discards responses belonging to flushed requests. It also sequences instruction fences by holding issue until every in-flight request has drained. It generalises the fixed two-entry attribute tracking to `DEPTH` entries and `NUM_SUB_UNITS` sources, and adds protocol-error detection.

## Interface
- `DEPTH`, default 2: maximum outstanding requests; power of two, 2..16.
- `NUM_SUB_UNITS`, default 3: response sources, 1..8. `SUB_W = (NUM_SUB_UNITS==1) ? 1 : $clog2(NUM_SUB_UNITS)`. `CNT_W = $clog2(DEPTH+1)`.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  issue logic pushes a request; legal only when `req_ready`.
- `req_ready`  out  1  tracker can accept a request.
- `req_subunit_id`  in  SUB_W  responding sub-unit index.
- `req_fault`  in  1  request raised an MMU or access fault; no sub-unit response will arrive.
- `req_predicted`, `req_is_branch`  in  1 each  branch-predictor attributes.
- `req_next_pc`  in  32  PC+4 of the request.
- `flush`  in  1  drop every request in flight, including one pushed this cycle.
- `ifence`  in  1  one-cycle instruction-fence request.
- `ifence_start`  out  1  one-cycle pulse to the icache: the fence may begin.
- `unit_data_valid`  in  NUM_SUB_UNITS  per-source response strobe.
- `unit_data`  in  NUM_SUB_UNITS*32  per-source instruction word; source i occupies bits [32i+31:32i].
- `rsp_valid`  out  1  a surviving request completes this cycle.
- `rsp_instruction`  out  32  instruction word from the head request's sub-unit.
- `rsp_fault`, `rsp_predicted`, `rsp_is_branch`  out  1 each  head attributes.
- `rsp_next_pc`  out  32  head `req_next_pc`; used as the early-flush target.
- `inflight_count`  out  CNT_W  number of occupied entries.
- `protocol_error`  out  1  sticky error flag.

## Operation
- Storage is a circular queue of `DEPTH` entries with head and tail pointers of width `$clog2(DEPTH)`. Pointers wrap modulo `DEPTH`.
- Push occurs on `req_valid & req_ready`.
- `req_ready = ~full & ~ifence_pending`.
- Head completion `pop = head_valid & (head.fault | unit_data_valid[head.subunit_id])`.
- `inflight_next = inflight_count + push - pop`. Compute at CNT_W width; it never under- or overflows under legal use.
- Drop counter `drop_count` (CNT_W) is updated with this priority:
  1. On `flush`, load `inflight_next`.
  2. Otherwise, on `pop` with `drop_count != 0`, decrement.
- `rsp_valid = pop & (drop_count == 0)`. A popped request with a nonzero drop count is discarded silently.
- Fence: `ifence` sets `ifence_pending`.
  - `ifence_start = ifence_pending & (inflight_next == 0)`.
  - `ifence_pending` clears in the cycle `ifence_start` is asserted.
  - An `ifence` asserted while a fence is already pending is absorbed.
- `protocol_error` sets and stays set on any of:
  - any `unit_data_valid` bit set while the queue is empty;
  - a set bit other than `head.subunit_id`;
  - `unit_data_valid[head.subunit_id]` set while `head.fault` is 1;
  - `req_valid` asserted while `req_ready` is 0.
  - On an illegal push the push is ignored.

## Timing
- Reset (asynchronous): pointers, `inflight_count`, `drop_count`, `ifence_pending` and `protocol_error` are 0. `req_ready` is 1; `rsp_valid` and `ifence_start` are 0.
- A request pushed in cycle N is at the head no earlier than N+1. A faulting request completes in N+1 when it is at the head.
- Response path is combinational: `unit_data_valid` to `rsp_*` in the same cycle, with no output register.
- With the queue full, simultaneous pop and push is not possible because `req_ready` is 0. The push is accepted the cycle after the pop.
- Simultaneous push and pop on a non-full queue leaves `inflight_count` unchanged.
- `flush` in the same cycle as a pop: the pop is excluded from `inflight_next`, so the drop count covers only the remaining entries.
- `flush` in the same cycle as a push: the pushed request is counted and dropped.
- `ifence` in the same cycle as `inflight_next == 0`: `ifence_start` pulses the following cycle, once pending is registered.

## Structure
- Add `fetch_tracker_attr_t` (fault, predicted, is_branch, next_pc, subunit_id) to `cva5_types`. Its `subunit_id` width comes from a package function of `NUM_SUB_UNITS`.
- Put the queue in one sub-module, `fetch_attr_queue`. It is parametrised on `DEPTH` and the data type, has an asynchronous active-low reset, and exposes full, valid, push and pop.

## Test plan
- Reset: with `DEPTH=4`, deassert `rst_n` mid-traffic → `inflight_count=0`, `req_ready=1`, `rsp_valid=0` on the same edge.
- In-order completion: push 4 requests to sub-units 2,0,1,2 → `req_ready=0`; data_valid in that order returns words 0x13,0x6F,0x63,0x67 with `rsp_valid` each cycle.
- Flush drop: with 3 requests in flight, `flush` concurrent with a 4th push → the next 4 completions give `rsp_valid=0`; the 5th request responds normally.
- Fault bypass: push with `req_fault=1` → `rsp_valid=1`, `rsp_fault=1` one cycle later without any `unit_data_valid`.
- Fence: `ifence` with 2 in flight → `req_ready=0`; `ifence_start` pulses exactly once, in the cycle the 2nd response pops.
- Error: `unit_data_valid=3'b100` while the head subunit is 0 → `protocol_error=1` and it stays set until reset.

Source files
------------

// File: rtl/cva5_types_pkg.sv
// Shared CVA5 fetch-stage types: per-request attribute record kept by the fetch tracker.
package cva5_types;

    localparam int unsigned MAX_SUB_UNITS = 8;

    function automatic int unsigned subunit_id_w(input int unsigned num_sub_units);
        return (num_sub_units <= 1) ? 1 : $clog2(num_sub_units);
    endfunction

    // Sized for the largest supported source count so one record type fits every configuration.
    localparam int unsigned ATTR_SUB_W = subunit_id_w(MAX_SUB_UNITS);

    typedef struct packed {
        logic                  fault;
        logic                  predicted;
        logic                  is_branch;
        logic [31:0]           next_pc;
        logic [ATTR_SUB_W-1:0] subunit_id;
    } fetch_tracker_attr_t;

endpackage

// File: rtl/fetch_attr_queue.sv
// Circular in-order queue of request attributes; head entry is read combinationally.
module fetch_attr_queue #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  T                 push_data,
    output T                 head_data,
    output logic             full,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail_ptr] <= push_data;
                tail_ptr      <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[head_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign valid     = (count != '0);

endmodule

// File: rtl/fetch_request_tracker.sv
// In-order tracker for outstanding fetch requests: response matching, flush drop and fence sequencing.
module fetch_request_tracker
    import cva5_types::*;
#(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned NUM_SUB_UNITS = 3,
    localparam int unsigned SUB_W = (NUM_SUB_UNITS == 1) ? 1 : $clog2(NUM_SUB_UNITS),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SUB_W-1:0]           req_subunit_id,
    input  logic                       req_fault,
    input  logic                       req_predicted,
    input  logic                       req_is_branch,
    input  logic [31:0]                req_next_pc,
    input  logic                       flush,
    input  logic                       ifence,
    output logic                       ifence_start,
    input  logic [NUM_SUB_UNITS-1:0]   unit_data_valid,
    input  logic [NUM_SUB_UNITS*32-1:0] unit_data,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_instruction,
    output logic                       rsp_fault,
    output logic                       rsp_predicted,
    output logic                       rsp_is_branch,
    output logic [31:0]                rsp_next_pc,
    output logic [CNT_W-1:0]           inflight_count,
    output logic                       protocol_error
);

    fetch_tracker_attr_t       push_attr;
    fetch_tracker_attr_t       head;
    logic                      full;
    logic                      head_valid;
    logic                      push;
    logic                      pop;
    logic                      illegal_push;
    logic [NUM_SUB_UNITS-1:0]  head_sel;
    logic [31:0]               sel_data;
    logic                      sel_valid;
    logic                      stray_valid;
    logic [CNT_W-1:0]          inflight_next;
    logic [CNT_W-1:0]          drop_count;
    logic                      ifence_pending;
    logic                      error_c;

    assign req_ready    = ~full & ~ifence_pending;
    assign push         = req_valid & req_ready;
    assign illegal_push = req_valid & ~req_ready;

    always_comb begin
        push_attr            = '0;
        push_attr.fault      = req_fault;
        push_attr.predicted  = req_predicted;
        push_attr.is_branch  = req_is_branch;
        push_attr.next_pc    = req_next_pc;
        push_attr.subunit_id = ATTR_SUB_W'(req_subunit_id);
    end

    fetch_attr_queue #(
        .DEPTH (DEPTH),
        .T     (fetch_tracker_attr_t)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_attr),
        .head_data (head),
        .full      (full),
        .valid     (head_valid),
        .count     (inflight_count)
    );

    // One-hot of the head's source and its instruction word.
    always_comb begin
        head_sel = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SUB_UNITS; i++) begin
            if (head.subunit_id == ATTR_SUB_W'(i)) begin
                head_sel[i] = 1'b1;
                sel_data    = unit_data[32*i +: 32];
            end
        end
    end

    assign sel_valid     = |(unit_data_valid & head_sel);
    assign stray_valid   = |(unit_data_valid & ~head_sel);
    assign pop           = head_valid & (head.fault | sel_valid);
    assign inflight_next = inflight_count + CNT_W'(push) - CNT_W'(pop);

    assign rsp_valid       = pop & (drop_count == '0);
    assign rsp_instruction = sel_data;
    assign rsp_fault       = head.fault;
    assign rsp_predicted   = head.predicted;
    assign rsp_is_branch   = head.is_branch;
    assign rsp_next_pc     = head.next_pc;

    assign ifence_start = ifence_pending & (inflight_next == '0);

    assign error_c = (~head_valid & (|unit_data_valid))
                   | (head_valid & (stray_valid | (head.fault & sel_valid)))
                   | illegal_push;

    // Flush marks everything still in flight after this cycle for silent discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (flush) begin
            drop_count <= inflight_next;
        end else if (pop && (drop_count != '0)) begin
            drop_count <= drop_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifence_pending <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (ifence_start) begin
                ifence_pending <= 1'b0;
            end else if (ifence) begin
                ifence_pending <= 1'b1;
            end
            if (error_c) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_request_tracker.sv
// Directed bench for fetch_request_tracker with DEPTH=4 and three sub-units.
module tb_fetch_request_tracker;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned NSU   = 3;
    localparam int unsigned SUB_W = 2;
    localparam int unsigned CNT_W = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [SUB_W-1:0]     req_subunit_id;
    logic                 req_fault;
    logic                 req_predicted;
    logic                 req_is_branch;
    logic [31:0]          req_next_pc;
    logic                 flush;
    logic                 ifence;
    logic                 ifence_start;
    logic [NSU-1:0]       unit_data_valid;
    logic [NSU*32-1:0]    unit_data;
    logic                 rsp_valid;
    logic [31:0]          rsp_instruction;
    logic                 rsp_fault;
    logic                 rsp_predicted;
    logic                 rsp_is_branch;
    logic [31:0]          rsp_next_pc;
    logic [CNT_W-1:0]     inflight_count;
    logic                 protocol_error;

    int n_cmp = 0;
    int n_err = 0;

    fetch_request_tracker #(.DEPTH(DEPTH), .NUM_SUB_UNITS(NSU)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_subunit_id  (req_subunit_id),
        .req_fault       (req_fault),
        .req_predicted   (req_predicted),
        .req_is_branch   (req_is_branch),
        .req_next_pc     (req_next_pc),
        .flush           (flush),
        .ifence          (ifence),
        .ifence_start    (ifence_start),
        .unit_data_valid (unit_data_valid),
        .unit_data       (unit_data),
        .rsp_valid       (rsp_valid),
        .rsp_instruction (rsp_instruction),
        .rsp_fault       (rsp_fault),
        .rsp_predicted   (rsp_predicted),
        .rsp_is_branch   (rsp_is_branch),
        .rsp_next_pc     (rsp_next_pc),
        .inflight_count  (inflight_count),
        .protocol_error  (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input int sub, input logic f, input logic [31:0] pc);
        req_valid      = v;
        req_subunit_id = SUB_W'(sub);
        req_fault      = f;
        req_next_pc    = pc;
    endtask

    task automatic set_rsp(input int sub, input logic [31:0] word);
        unit_data_valid = '0;
        unit_data       = '0;
        unit_data_valid[sub] = 1'b1;
        unit_data[32*sub +: 32] = word;
    endtask

    task automatic clr_rsp();
        unit_data_valid = '0;
        unit_data       = '0;
    endtask

    int          subs [4] = '{2, 0, 1, 2};
    logic [31:0] words[4] = '{32'h13, 32'h6F, 32'h63, 32'h67};

    initial begin
        rst_n = 1'b0;
        set_req(1'b0, 0, 1'b0, 32'h0);
        req_predicted = 1'b0;
        req_is_branch = 1'b0;
        flush  = 1'b0;
        ifence = 1'b0;
        clr_rsp();
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_count", 32'(inflight_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ifence_start", 32'(ifence_start), 32'd0);
        chk("rst_perr", 32'(protocol_error), 32'd0);

        // In-order fill to full, then drain in issue order
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, subs[i], 1'b0, 32'h104 + 32'(4 * i));
            #1;
            chk("fill_ready", 32'(req_ready), 32'd1);
            cyc();
        end
        set_req(1'b0, 0, 1'b0, 32'h0);
        #1;
        chk("full_count", 32'(inflight_count), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_rsp(subs[i], words[i]);
            #1;
            chk("inorder_valid", 32'(rsp_valid), 32'd1);
            chk("inorder_instr", rsp_instruction, words[i]);
            chk("inorder_pc", rsp_next_pc, 32'h104 + 32'(4 * i));
            cyc();
            if (i == 0) chk("ready_after_pop", 32'(req_ready), 32'd1);
        end
        clr_rsp();
        #1;
        chk("drain_count", 32'(inflight_count), 32'd0);

        // Faulting request completes without a sub-unit response
        set_req(1'b1, 0, 1'b1, 32'h200);
        #1;
        chk("fault_not_same_cycle", 32'(rsp_valid), 32'd0);
        cyc();
        set_req(1'b0, 0, 1'b0, 32'h0);
        #1;
        chk("fault_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fault_rsp_fault", 32'(rsp_fault), 32'd1);
        chk("fault_rsp_pc", rsp_next_pc, 32'h200);
        cyc();
        chk("fault_count", 32'(inflight_count), 32'd0);

        // Flush with 3 in flight plus a concurrent 4th push
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, i, 1'b0, 32'h300 + 32'(4 * i));
            cyc();
        end
        set_req(1'b1, 0, 1'b0, 32'h30C);
        flush = 1'b1;
        cyc();
        set_req(1'b0, 0, 1'b0, 32'h0);
        flush = 1'b0;
        #1;
        chk("flush_count", 32'(inflight_count), 32'd4);
        set_rsp(0, 32'hDEAD0000);
        #1;
        chk("drop1", 32'(rsp_valid), 32'd0);
        cyc();
        set_rsp(1, 32'hDEAD0001);
        set_req(1'b1, 1, 1'b0, 32'h410);
        #1;
        chk("drop2", 32'(rsp_valid), 32'd0);
        chk("drop2_ready", 32'(req_ready), 32'd1);
        cyc();
        set_req(1'b0, 0, 1'b0, 32'h0);
        #1;
        chk("push_pop_count", 32'(inflight_count), 32'd3);
        set_rsp(2, 32'hDEAD0002);
        #1;
        chk("drop3", 32'(rsp_valid), 32'd0);
        cyc();
        set_rsp(0, 32'hDEAD0003);
        #1;
        chk("drop4", 32'(rsp_valid), 32'd0);
        cyc();
        set_rsp(1, 32'h0000ABCD);
        #1;
        chk("post_flush_valid", 32'(rsp_valid), 32'd1);
        chk("post_flush_instr", rsp_instruction, 32'h0000ABCD);
        chk("post_flush_pc", rsp_next_pc, 32'h410);
        cyc();
        clr_rsp();
        #1;
        chk("post_flush_count", 32'(inflight_count), 32'd0);

        // Fence with two requests in flight
        set_req(1'b1, 0, 1'b0, 32'h500);
        cyc();
        set_req(1'b1, 1, 1'b0, 32'h504);
        cyc();
        set_req(1'b0, 0, 1'b0, 32'h0);
        ifence = 1'b1;
        #1;
        chk("fence_req_cycle", 32'(ifence_start), 32'd0);
        cyc();
        ifence = 1'b0;
        #1;
        chk("fence_ready", 32'(req_ready), 32'd0);
        chk("fence_wait0", 32'(ifence_start), 32'd0);
        set_rsp(0, 32'h1);
        #1;
        chk("fence_wait1", 32'(ifence_start), 32'd0);
        cyc();
        set_rsp(1, 32'h2);
        #1;
        chk("fence_start", 32'(ifence_start), 32'd1);
        chk("fence_last_rsp", 32'(rsp_valid), 32'd1);
        cyc();
        clr_rsp();
        #1;
        chk("fence_once", 32'(ifence_start), 32'd0);
        chk("fence_ready_back", 32'(req_ready), 32'd1);

        // Fence requested with nothing in flight starts the next cycle
        ifence = 1'b1;
        #1;
        chk("efence_same", 32'(ifence_start), 32'd0);
        cyc();
        ifence = 1'b0;
        #1;
        chk("efence_start", 32'(ifence_start), 32'd1);
        chk("efence_ready", 32'(req_ready), 32'd0);
        cyc();
        chk("efence_done", 32'(ifence_start), 32'd0);
        chk("efence_ready_back", 32'(req_ready), 32'd1);
        chk("no_perr_yet", 32'(protocol_error), 32'd0);

        // Wrong source responds while head belongs to sub-unit 0
        set_req(1'b1, 0, 1'b0, 32'h700);
        cyc();
        set_req(1'b0, 0, 1'b0, 32'h0);
        unit_data_valid = 3'b100;
        #1;
        chk("err_no_rsp", 32'(rsp_valid), 32'd0);
        cyc();
        clr_rsp();
        #1;
        chk("err_set", 32'(protocol_error), 32'd1);
        cyc();
        cyc();
        chk("err_sticky", 32'(protocol_error), 32'd1);
        chk("err_count", 32'(inflight_count), 32'd1);

        // Asynchronous reset in the middle of traffic
        set_req(1'b1, 1, 1'b0, 32'h800);
        set_rsp(0, 32'h55);
        #1;
        chk("pre_rst_rsp", 32'(rsp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(inflight_count), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_perr", 32'(protocol_error), 32'd0);
        set_req(1'b0, 0, 1'b0, 32'h0);
        clr_rsp();
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
